// File: rtl/clm_unmask_decode_pkg.sv
// Shared types and constants for the CLM unmasking decoder.
// The optional CLM_UNMASK_ZEROIZE_EN build is handled in the top module.
package clm_unmask_decode_pkg;

    localparam int CLM_D     = 2;
    localparam int CLM_N     = 8 + CLM_D;
    localparam int CLM_NB    = 16;
    localparam int CLM_LANES = 4;

    typedef logic [CLM_NB-1:0][CLM_N-1:0] state_t;
    typedef logic [CLM_N-1:0][7:0]        dec_matrix_t;
    typedef logic [CLM_NB-1:0][7:0]       plain_t;

    // Row-wise GF(2) product: each set codeword bit folds its matrix row into the byte.
    function automatic logic [7:0] gf2_word_mul(input logic [CLM_N-1:0] word,
                                                input dec_matrix_t      mat);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < CLM_N; i++) begin
            acc = acc ^ (mat[i] & {8{word[i]}});
        end
        return acc;
    endfunction

endpackage

// File: rtl/clm_unmask_decode_mul_dec.sv
// Combinational n-bit codeword times decoding matrix, giving the plain byte.
module clm_unmask_decode_mul_dec
    import clm_unmask_decode_pkg::*;
(
    input  logic [CLM_N-1:0] word_i,
    input  dec_matrix_t      mat_i,
    output logic [7:0]       byte_o
);

    // Pure GF(2) product, no state.
    always_comb begin
        byte_o = gf2_word_mul(word_i, mat_i);
    end

endmodule

// File: rtl/clm_unmask_decode.sv
// Sequential unmasking decoder: LANES codewords per cycle, IDLE/RUN/HOLD handshake FSM.
// Build option: define CLM_UNMASK_ZEROIZE_EN to clear buf/mreg/out_plain on output handshake.
module clm_unmask_decode
    import clm_unmask_decode_pkg::*;
#(
    parameter int LANES = CLM_LANES
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  state_t      in_state,
    input  dec_matrix_t dec_m,
    output logic        out_valid,
    input  logic        out_ready,
    output plain_t      out_plain
);

    localparam int STEPS = CLM_NB / LANES;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int IDX_W = $clog2(CLM_NB);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    if (CLM_NB % LANES != 0) begin : g_lanes_check
        $error("clm_unmask_decode: LANES must divide NB");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fsm_e;

    fsm_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           buf_q, buf_d;
    dec_matrix_t      mreg_q, mreg_d;
    plain_t           plain_q, plain_d;
    logic             valid_q, valid_d;
    logic             in_ready_q;

    logic [CLM_N-1:0] lane_word_s [LANES];
    logic [7:0]       lane_byte_s [LANES];

    // Select the words handled in the current RUN step.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_word_s[l] = buf_q[IDX_W'(int'(cnt_q) * LANES + l)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        clm_unmask_decode_mul_dec u_mul_dec (
            .word_i (lane_word_s[g]),
            .mat_i  (mreg_q),
            .byte_o (lane_byte_s[g])
        );
    end

    // Next-state and datapath update for the handshake FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        mreg_d  = mreg_q;
        plain_d = plain_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    buf_d   = in_state;
                    mreg_d  = dec_m;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    plain_d[IDX_W'(int'(cnt_q) * LANES + l)] = lane_byte_s[l];
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
`ifdef CLM_UNMASK_ZEROIZE_EN
                    buf_d   = '0;
                    mreg_d  = '0;
                    plain_d = '0;
`endif
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; in_ready stays low through reset, high whenever idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            mreg_q     <= '0;
            plain_q    <= '0;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            mreg_q     <= mreg_d;
            plain_q    <= plain_d;
            valid_q    <= valid_d;
            in_ready_q <= (state_d == S_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = valid_q;
    assign out_plain = plain_q;

endmodule

// File: tb/tb_clm_unmask_decode.sv
// Randomized self-checking bench for clm_unmask_decode against a behavioural model.
module tb_clm_unmask_decode;
    import clm_unmask_decode_pkg::*;

    localparam int LAT = CLM_NB / CLM_LANES;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    state_t      in_state = '0;
    dec_matrix_t dec_m = '0;
    logic        in_ready;
    logic        out_valid;
    plain_t      out_plain;

    int n_cmp = 0;
    int n_mis = 0;

    clm_unmask_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .dec_m     (dec_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_plain (out_plain)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [CLM_NB*8-1:0] got,
                         input logic [CLM_NB*8-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Column-parity view: output bit j is the parity of the word masked by column j.
    function automatic plain_t ref_decode(input state_t st, input dec_matrix_t m);
        plain_t p;
        logic [CLM_N-1:0] col;
        for (int k = 0; k < CLM_NB; k++) begin
            for (int j = 0; j < 8; j++) begin
                for (int i = 0; i < CLM_N; i++) col[i] = m[i][j];
                p[k][j] = ^(st[k] & col);
            end
        end
        return p;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int k = 0; k < CLM_NB; k++) s[k] = CLM_N'($urandom);
        return s;
    endfunction

    function automatic dec_matrix_t rand_matrix();
        dec_matrix_t m;
        for (int i = 0; i < CLM_N; i++) m[i] = 8'($urandom);
        return m;
    endfunction

    // Encoder: codeword = {r, x ^ r*A}; matching Dm = identity rows stacked on A.
    task automatic make_masked(input bit fixed_x, output state_t st,
                               output dec_matrix_t m, output plain_t xs);
        logic [7:0] a [CLM_D];
        logic [7:0] one;
        logic [7:0] x;
        logic [7:0] ra;
        logic [CLM_D-1:0] rr;
        one = 8'h01;
        for (int r = 0; r < CLM_D; r++) a[r] = 8'($urandom);
        for (int i = 0; i < 8; i++) m[i] = one << i;
        for (int r = 0; r < CLM_D; r++) m[8 + r] = a[r];
        for (int k = 0; k < CLM_NB; k++) begin
            x  = fixed_x ? 8'hA5 : 8'($urandom);
            rr = CLM_D'($urandom);
            ra = 8'h00;
            for (int r = 0; r < CLM_D; r++) if (rr[r]) ra = ra ^ a[r];
            st[k] = {rr, x ^ ra};
            xs[k] = x;
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int b;
        b = 0;
        while (!in_ready && b < 50) begin
            step();
            b++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic run_state(input string tag, input state_t st, input dec_matrix_t m,
                             input plain_t exp, input int hold_cycles);
        in_state = st;
        dec_m    = m;
        in_valid = 1'b1;
        wait_ready(tag);
        step();
        in_valid = 1'b0;
        in_state = rand_state();
        dec_m    = rand_matrix();
        for (int k = 1; k <= LAT; k++) begin
            step();
            check({tag, "_lat_valid"}, out_valid, (k == LAT) ? 1 : 0);
        end
        check({tag, "_plain"}, out_plain, exp);
        check({tag, "_busy"}, in_ready, 0);
        for (int h = 0; h < hold_cycles; h++) begin
            step();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_plain"}, out_plain, exp);
            check({tag, "_hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_done_ready"}, in_ready, 1);
`ifdef CLM_UNMASK_ZEROIZE_EN
        check({tag, "_done_plain"}, out_plain, '0);
`else
        check({tag, "_done_plain"}, out_plain, exp);
`endif
    endtask

    initial begin
        state_t      st;
        state_t      st_b;
        dec_matrix_t m;
        dec_matrix_t m_b;
        plain_t      xs;
        plain_t      exp;
        plain_t      exp_b;
        logic [7:0]  one;
        int          k;
        bit          seen;

        repeat (3) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_plain", out_plain, '0);
        rst_n = 1'b1;
        step();
        step();

        // Identity selection of bits [7:0]
        one = 8'h01;
        m = '0;
        for (int i = 0; i < 8; i++) m[i] = one << i;
        for (int w = 0; w < CLM_NB; w++) begin
            st[w]  = {2'b11, 8'(w * 17)};
            exp[w] = 8'(w * 17);
        end
        run_state("ident", st, m, exp, 0);

        // Mask cancellation with constant plaintext; one run under 10-cycle backpressure
        for (int s = 0; s < 7; s++) begin
            make_masked(1'b1, st, m, xs);
            for (int w = 0; w < CLM_NB; w++) exp[w] = 8'hA5;
            check("mask_enc_model", xs, exp);
            run_state("mask_a5", st, m, exp, (s == 2) ? 10 : int'($urandom_range(0, 3)));
        end

        for (int s = 0; s < 3; s++) begin
            make_masked(1'b0, st, m, xs);
            run_state("mask_rnd", st, m, xs, int'($urandom_range(0, 2)));
        end

        // Arbitrary matrices against the column-parity model
        for (int s = 0; s < 5; s++) begin
            st = rand_state();
            m  = rand_matrix();
            run_state("rand_dm", st, m, ref_decode(st, m), int'($urandom_range(0, 2)));
        end

        // Back-to-back: second state waits for the first handshake
        make_masked(1'b0, st, m, exp);
        st_b  = rand_state();
        m_b   = rand_matrix();
        exp_b = ref_decode(st_b, m_b);
        out_ready = 1'b1;
        in_state  = st;
        dec_m     = m;
        in_valid  = 1'b1;
        wait_ready("b2b");
        step();
        in_state = st_b;
        dec_m    = m_b;
        k    = 0;
        seen = 1'b0;
        while (!in_ready && k < 50) begin
            step();
            k++;
            if (out_valid) begin
                seen = 1'b1;
                check("b2b_first_plain", out_plain, exp);
            end
        end
        check("b2b_first_seen", seen, 1);
        check("b2b_gap", k + 1, LAT + 2);
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            step();
            k++;
        end
        check("b2b_second_valid", out_valid, 1);
        check("b2b_second_plain", out_plain, exp_b);
        step();
        out_ready = 1'b0;
        step();

        // Reset during RUN discards the partial result
        st = rand_state();
        m  = rand_matrix();
        in_state = st;
        dec_m    = m;
        in_valid = 1'b1;
        wait_ready("rst_run");
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_plain", out_plain, '0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 2 * LAT; c++) begin
            step();
            check("post_rst_valid", out_valid, 0);
        end
        check("post_rst_ready", in_ready, 1);
        check("post_rst_plain", out_plain, '0);
        make_masked(1'b1, st, m, xs);
        run_state("post_rst", st, m, xs, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/clm_unmask_decode.md
Name: clm_unmask_decode

Overview:
- Sequential unmasking decoder for the CLM datapath; inverse of the add-random-codeword encoder.
- Accepts a masked state of NB n-bit codewords, each encoded as x·G ^ r·P with n = 8+d.
- Multiplies each word by the n×8 decoding matrix (G·Dm = I, P·Dm = 0), removing the mask and recovering the plain byte.
- Processes LANES words per cycle under valid/ready handshakes; sits at the CLM core output before ciphertext leaves the masked domain.

Parameters:
- d, 2, masking order; codeword width n = 8+d.
- NB, 16, words per state.
- LANES, 4, words decoded per cycle; must divide NB (elaboration error otherwise).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  masked state and matrix present.
- in_ready  output  1  block can accept a state.
- in_state  input  state_t (NB×n)  masked state.
- dec_m  input  dec_matrix_t (n×8)  decoding matrix.
- out_valid  output  1  plain state available.
- out_ready  input  1  downstream accepts.
- out_plain  output  plain_t (NB×8)  unmasked state.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, in_ready=0 during reset then 1, out_valid=0, out_plain=0, word counter=0, internal state/matrix registers=0.
- Input transfer: in_valid && in_ready in IDLE captures in_state into buf and dec_m into mreg, counter=0, FSM→RUN. Later changes to dec_m have no effect on a capture in flight.
- in_ready=1 only in IDLE.
- RUN: each cycle decodes words [cnt*LANES .. cnt*LANES+LANES-1] of buf with mreg and writes the results into the matching bytes of out_plain.
  - Per word: bit j of the output = XOR over i of (word[i] & mreg[i][j]).
  - After the cycle with cnt = NB/LANES-1: FSM→HOLD, out_valid=1. Otherwise cnt++.
- Latency: NB/LANES cycles from the accept edge to out_valid=1 (4 with defaults).
- HOLD: out_valid and out_plain stay stable until out_ready=1.
  - On an out_valid && out_ready edge: out_valid=0, FSM→IDLE, in_ready=1 on the next cycle. There is no same-cycle refill; throughput is one state per NB/LANES+2 cycles.
- out_ready asserted outside HOLD is ignored. in_valid outside IDLE is ignored; the source must hold it.
- rst_n asserted mid-RUN or mid-HOLD: immediate return to the reset values. The partial result is discarded and out_valid never pulses.
- out_plain bytes not yet written during RUN hold their previous contents. Only the HOLD value is meaningful.
- Arithmetic is GF(2) only; no carries and no width growth.

Optional Feature:
- Macro: CLM_UNMASK_ZEROIZE_EN.
- Defined: on the output handshake edge, buf, mreg and out_plain clear to 0 in the same cycle FSM→IDLE, so out_plain reads 0 while idle. Limits the lifetime of unmasked and share data.
- Undefined: registers retain their last values; out_plain keeps the last result after the handshake.

Decomposition:
- Shared package types: dec_matrix_t (n×8 bit array), plain_t (NB×8), NB constant, and the derived n = 8+d. state_t is reused unchanged.
- FSM state enum (IDLE/RUN/HOLD) stays local.
- Sub-module mul_dec: combinational n-bit word × dec_matrix_t → 8-bit.
  - Instantiated LANES times.
  - Reusable by the fault-check path.

Test Plan:
- d=2, n=10, dec_m selects bits[7:0] (mreg[i][j]=1 iff i==j), word k = {2'b11, 8'(k*17)}: out_plain byte k = k*17 (e.g. byte 3 = 8'h33); out_valid rises exactly 4 cycles after the accept.
- Mask cancellation: x=8'hA5 in all words; encode with a random r through the encoder for 100 random (r, x) pairs; decode with the matching Dm → every byte = 8'hA5.
- Backpressure: out_ready=0 for 10 cycles in HOLD → out_plain stable, out_valid=1, in_ready=0; then 1-cycle out_ready → in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with two states queued → the second state is accepted only after the first handshake, 6 cycles apart with defaults.
- rst_n pulsed low in cycle 2 of RUN → out_valid=0, in_ready=1 after release, out_plain=0; a fresh state then decodes correctly.
- With CLM_UNMASK_ZEROIZE_EN defined: after the handshake, out_plain=0 next cycle; without the macro, it retains the value (e.g. 16×8'hA5).
